// File: rtl/intersection_phase_scheduler_if.sv
// Signal bundle between the tick/request side and the lamp-driver side of the
// intersection phase scheduler.
interface intersection_phase_scheduler_if;
  logic        tick;
  logic [3:0]  ped_req;
  logic        emerg_req;
  logic        emerg_dir;
  logic [2:0]  ns_rgy;
  logic [2:0]  ew_rgy;
  logic [3:0]  ped_walk;
  logic [3:0]  ped_pending;
  logic [2:0]  state_out;
  logic [15:0] sec_left;

  modport master (
    output tick, ped_req, emerg_req, emerg_dir,
    input  ns_rgy, ew_rgy, ped_walk, ped_pending, state_out, sec_left
  );

  modport slave (
    input  tick, ped_req, emerg_req, emerg_dir,
    output ns_rgy, ew_rgy, ped_walk, ped_pending, state_out, sec_left
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Phase sequencer for the Tudor intersection: NS/EW green-yellow-clear cycle,
// latched all-red pedestrian walk phase and emergency-vehicle preemption.
module intersection_phase_scheduler #(
  parameter int unsigned T_GREEN  = 10,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_CLEAR  = 1,
  parameter int unsigned T_PED    = 8
) (
  input logic clk,
  input logic rst_n,
  intersection_phase_scheduler_if.slave bus
);

  localparam logic [2:0] NS_GRN  = 3'd0;
  localparam logic [2:0] NS_YEL  = 3'd1;
  localparam logic [2:0] NS_CLR  = 3'd2;
  localparam logic [2:0] EW_GRN  = 3'd3;
  localparam logic [2:0] EW_YEL  = 3'd4;
  localparam logic [2:0] EW_CLR  = 3'd5;
  localparam logic [2:0] PED     = 3'd6;
  localparam logic [2:0] PED_CLR = 3'd7;

  localparam logic [15:0] D_GRN = (T_GREEN  == 0) ? 16'd1 : T_GREEN[15:0];
  localparam logic [15:0] D_YEL = (T_YELLOW == 0) ? 16'd1 : T_YELLOW[15:0];
  localparam logic [15:0] D_CLR = (T_CLEAR  == 0) ? 16'd1 : T_CLEAR[15:0];
  localparam logic [15:0] D_PED = (T_PED    == 0) ? 16'd1 : T_PED[15:0];

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [2:0]  state_q, state_d;
  logic [15:0] sec_q, sec_d;
  logic        next_dir_q, next_dir_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  walk_q, walk_d;

  logic        go, reload, expired, any_ped;
  logic [2:0]  tgt, emerg_grn, clr_tgt_ns, clr_tgt_ew;
  logic [3:0]  req_all;

  function automatic logic [15:0] dur_of(input logic [2:0] s);
    case (s)
      NS_GRN, EW_GRN: dur_of = D_GRN;
      NS_YEL, EW_YEL: dur_of = D_YEL;
      PED:            dur_of = D_PED;
      default:        dur_of = D_CLR;
    endcase
  endfunction

  always_comb begin
    req_all    = pend_q | bus.ped_req;
    any_ped    = |req_all;
    expired    = bus.tick && (sec_q <= 16'd1);
    emerg_grn  = bus.emerg_dir ? EW_GRN : NS_GRN;
    clr_tgt_ns = bus.emerg_req ? emerg_grn : (any_ped ? PED : EW_GRN);
    clr_tgt_ew = bus.emerg_req ? emerg_grn : (any_ped ? PED : NS_GRN);

    state_d    = state_q;
    sec_d      = sec_q;
    next_dir_d = next_dir_q;
    pend_d     = req_all;
    walk_d     = walk_q;
    go         = 1'b0;
    reload     = 1'b0;
    tgt        = state_q;

    // Preemption acts on the very next clock; only the timer waits for tick.
    case (state_q)
      NS_GRN: begin
        if (bus.emerg_req && bus.emerg_dir) begin
          go = 1'b1; tgt = NS_YEL;
        end else if (bus.emerg_req) begin
          reload = 1'b1;
        end else if (expired) begin
          go = 1'b1; tgt = NS_YEL;
        end
      end
      EW_GRN: begin
        if (bus.emerg_req && !bus.emerg_dir) begin
          go = 1'b1; tgt = EW_YEL;
        end else if (bus.emerg_req) begin
          reload = 1'b1;
        end else if (expired) begin
          go = 1'b1; tgt = EW_YEL;
        end
      end
      NS_YEL:  if (expired) begin go = 1'b1; tgt = NS_CLR; end
      EW_YEL:  if (expired) begin go = 1'b1; tgt = EW_CLR; end
      NS_CLR:  if (expired) begin go = 1'b1; tgt = clr_tgt_ns; next_dir_d = 1'b1; end
      EW_CLR:  if (expired) begin go = 1'b1; tgt = clr_tgt_ew; next_dir_d = 1'b0; end
      PED:     if (expired) begin go = 1'b1; tgt = PED_CLR; end
      PED_CLR: begin
        if (expired) begin
          go  = 1'b1;
          tgt = bus.emerg_req ? emerg_grn : (next_dir_q ? EW_GRN : NS_GRN);
        end
      end
      default: begin go = 1'b1; tgt = EW_CLR; end
    endcase

    if (go) begin
      state_d = tgt;
      sec_d   = dur_of(tgt);
      walk_d  = '0;
      if (tgt == PED) begin
        walk_d = req_all;
        pend_d = '0;
      end
    end else if (reload) begin
      sec_d = D_GRN;
    end else if (bus.tick && sec_q != 16'd0) begin
      sec_d = sec_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EW_CLR;
      sec_q      <= D_CLR;
      next_dir_q <= 1'b0;
      pend_q     <= '0;
      walk_q     <= '0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      next_dir_q <= next_dir_d;
      pend_q     <= pend_d;
      walk_q     <= walk_d;
    end
  end

  always_comb begin
    bus.ns_rgy = LAMP_R;
    bus.ew_rgy = LAMP_R;
    case (state_q)
      NS_GRN:  bus.ns_rgy = LAMP_G;
      NS_YEL:  bus.ns_rgy = LAMP_Y;
      EW_GRN:  bus.ew_rgy = LAMP_G;
      EW_YEL:  bus.ew_rgy = LAMP_Y;
      default: ;
    endcase
  end

  assign bus.ped_walk    = walk_q;
  assign bus.ped_pending = pend_q;
  assign bus.state_out   = state_q;
  assign bus.sec_left    = sec_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed scoreboard bench for intersection_phase_scheduler with short
// durations (green 4, yellow 2, clear 1, ped 3).
module tb_intersection_phase_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  intersection_phase_scheduler_if bus();

  intersection_phase_scheduler #(
    .T_GREEN (4),
    .T_YELLOW(2),
    .T_CLEAR (1),
    .T_PED   (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [15:0] sec;
    logic [3:0]  walk;
    logic [3:0]  pend;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // {ns,ew} lamp pattern for a state
  function automatic logic [5:0] lamps(input logic [2:0] s);
    case (s)
      3'd0:    lamps = {3'b001, 3'b100};
      3'd1:    lamps = {3'b010, 3'b100};
      3'd3:    lamps = {3'b100, 3'b001};
      3'd4:    lamps = {3'b100, 3'b010};
      default: lamps = {3'b100, 3'b100};
    endcase
  endfunction

  task automatic push(input string tag, input logic [2:0] st, input logic [15:0] sec,
                      input logic [3:0] walk, input logic [3:0] pend);
    exp_t e;
    e.tag = tag; e.st = st; e.sec = sec; e.walk = walk; e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [32:0] obs, expv;
    logic [5:0]  l;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed no expectation, expected one queued");
      return;
    end
    e    = sb.pop_front();
    l    = lamps(e.st);
    obs  = {bus.state_out, bus.sec_left, bus.ns_rgy, bus.ew_rgy, bus.ped_walk, bus.ped_pending};
    expv = {e.st, e.sec, l, e.walk, e.pend};
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed state=%0d sec=%0d ns=%b ew=%b walk=%b pend=%b; expected state=%0d sec=%0d ns=%b ew=%b walk=%b pend=%b",
             e.tag, bus.state_out, bus.sec_left, bus.ns_rgy, bus.ew_rgy, bus.ped_walk, bus.ped_pending,
             e.st, e.sec, l[5:3], l[2:0], e.walk, e.pend);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    int d[6];
    d = '{4, 2, 1, 4, 2, 1};
    rst_n         = 1'b0;
    bus.tick      = 1'b0;
    bus.ped_req   = '0;
    bus.emerg_req = 1'b0;
    bus.emerg_dir = 1'b0;

    // reset and first tick
    push("reset", 3'd5, 16'd1, 4'b0, 4'b0);
    cyc(); cyc();
    check();
    rst_n = 1'b1;
    push("first_tick", 3'd0, 16'd4, 4'b0, 4'b0);
    do_tick();
    check();

    // idle period: each state lasts its duration, sec_left counts down
    for (int s = 0; s < 6; s++) begin
      for (int k = d[s]; k >= 1; k--) begin
        push("idle", 3'(s), 16'(k), 4'b0, 4'b0);
        check();
        do_tick();
      end
    end
    push("hold_no_tick", 3'd0, 16'd4, 4'b0, 4'b0);
    cyc(); cyc();
    check();

    // pedestrian request pulse in NS green
    push("ped_latch", 3'd0, 16'd4, 4'b0, 4'b0100);
    bus.ped_req = 4'b0100;
    cyc();
    bus.ped_req = '0;
    check();
    push("ped_enter", 3'd6, 16'd3, 4'b0100, 4'b0);
    ticks(7);
    check();
    push("ped_run", 3'd6, 16'd1, 4'b0100, 4'b0);
    ticks(2);
    check();
    push("ped_clr", 3'd7, 16'd1, 4'b0, 4'b0);
    ticks(1);
    check();
    push("ped_to_ew", 3'd3, 16'd4, 4'b0, 4'b0);
    ticks(1);
    check();
    push("back_ns", 3'd0, 16'd4, 4'b0, 4'b0);
    ticks(7);
    check();

    // preemption toward EW while NS is green
    push("e_pre", 3'd0, 16'd3, 4'b0, 4'b0);
    ticks(1);
    check();
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 1'b1;
    push("e_yel", 3'd1, 16'd2, 4'b0, 4'b0);
    cyc();
    check();
    push("e_yel2", 3'd1, 16'd1, 4'b0, 4'b0);
    ticks(1);
    check();
    push("e_clr", 3'd2, 16'd1, 4'b0, 4'b0);
    ticks(1);
    check();
    push("e_grn", 3'd3, 16'd4, 4'b0, 4'b0);
    ticks(1);
    check();
    push("e_hold", 3'd3, 16'd4, 4'b0, 4'b1000);
    bus.ped_req = 4'b1000;
    ticks(2);
    bus.ped_req = '0;
    check();
    bus.emerg_req = 1'b0;
    push("e_rel", 3'd3, 16'd1, 4'b0, 4'b1000);
    ticks(3);
    check();
    push("e_ew_yel", 3'd4, 16'd2, 4'b0, 4'b1000);
    ticks(1);
    check();
    push("e_ped", 3'd6, 16'd3, 4'b1000, 4'b0);
    ticks(3);
    check();
    push("e_ns", 3'd0, 16'd4, 4'b0, 4'b0);
    ticks(4);
    check();

    // preemption toward NS while NS is already green: timer held
    push("en_dec", 3'd0, 16'd3, 4'b0, 4'b0);
    ticks(1);
    check();
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 1'b0;
    push("en_hold", 3'd0, 16'd4, 4'b0, 4'b0);
    ticks(2);
    check();
    bus.emerg_req = 1'b0;
    push("en_rel", 3'd0, 16'd1, 4'b0, 4'b0);
    ticks(3);
    check();

    // request arriving with the final tick of EW_CLR
    push("t5_ewclr", 3'd5, 16'd1, 4'b0, 4'b0);
    ticks(10);
    check();
    push("t5_ped", 3'd6, 16'd3, 4'b0001, 4'b0);
    bus.ped_req = 4'b0001;
    bus.tick    = 1'b1;
    cyc();
    bus.ped_req = '0;
    bus.tick    = 1'b0;
    check();

    // reset during PED
    push("t6_pend", 3'd6, 16'd3, 4'b0001, 4'b0010);
    bus.ped_req = 4'b0010;
    cyc();
    bus.ped_req = '0;
    check();
    push("t6_rst", 3'd5, 16'd1, 4'b0, 4'b0);
    rst_n = 1'b0;
    cyc();
    check();
    rst_n = 1'b1;
    push("t6_after", 3'd0, 16'd4, 4'b0, 4'b0);
    ticks(1);
    check();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d leftover, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
